// File: rtl/flag_unit.sv
// -----------------------------------------------------------------------------
// flag_unit
//
// Producer side of the condition-code path. Computes N/Z/C/V from the ALU
// operands and result, carries them down a fixed-latency pipe, and owns the
// architectural flags register read by the condition-check logic. Also keeps a
// one-entry shadow copy of the flags for interrupt entry/return.
//
// Parameters
//   WIDTH  datapath width of op_a, op_b and result
//   LAT    pipe stages from accept to architectural write (legal 1..4)
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   valid_in      ALU result valid this cycle
//   opcode        instruction opcode
//   sbit          instruction requests a flag update
//   op_a, op_b    ALU operands (only the sign bits are used)
//   result        ALU result
//   alu_carry     adder carry-out (1 = no borrow for subtracts)
//   shift_carry   barrel-shifter carry-out
//   flush         kill every in-flight update
//   save          copy flags into the shadow
//   restore       load flags from the shadow (only when shadow_valid)
//   flags         architectural flags {N,Z,C,V}
//   flags_busy    at least one flag update in flight
//   shadow_valid  shadow holds saved flags
// -----------------------------------------------------------------------------
module flag_unit #(
   parameter int WIDTH = 16,
   parameter int LAT   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_in,
   input  logic [3:0]       opcode,
   input  logic             sbit,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [WIDTH-1:0] result,
   input  logic             alu_carry,
   input  logic             shift_carry,
   input  logic             flush,
   input  logic             save,
   input  logic             restore,
   output logic [3:0]       flags,
   output logic             flags_busy,
   output logic             shadow_valid
);

   localparam logic [3:0] OP_CMP = 4'b1000;

   // keep_v marks a logical op: V is not recomputed but copied from the
   // architectural V at the moment the update retires.
   typedef struct packed {
      logic valid;
      logic n;
      logic z;
      logic c;
      logic v;
      logic keep_v;
   } stage_t;

   stage_t     pipe [LAT];
   stage_t     stage_in;
   stage_t     last;
   logic [3:0] shadow;
   logic [3:0] retire_flags;
   logic       is_add;
   logic       is_sub;
   logic       upd;
   logic       do_restore;
   logic       kill;
   logic       a_msb;
   logic       b_msb;
   logic       r_msb;

   // Only the operand sign bits feed the overflow equations.
   logic unused_operand_bits;
   assign unused_operand_bits = ^{op_a[WIDTH-2:0], op_b[WIDTH-2:0]};

   assign a_msb = op_a[WIDTH-1];
   assign b_msb = op_b[WIDTH-1];
   assign r_msb = result[WIDTH-1];

   assign is_add = (opcode == 4'b0100) || (opcode == 4'b0101);
   assign is_sub = (opcode == 4'b0010) || (opcode == 4'b0011) || (opcode == OP_CMP);
   assign upd    = valid_in && (sbit || (opcode == OP_CMP));

   // A restore that takes effect discards the in-flight updates just like flush.
   assign do_restore = restore && shadow_valid;
   assign kill       = flush || do_restore;

   // NOTE: every signal written in always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      stage_in        = '0;
      stage_in.valid  = upd && !kill;
      stage_in.n      = r_msb;
      stage_in.z      = (result == '0);
      stage_in.keep_v = !(is_add || is_sub);
      if (is_add || is_sub) begin
         stage_in.c = alu_carry;
      end else begin
         stage_in.c = shift_carry;
      end
      if (is_add) begin
         stage_in.v = (a_msb == b_msb) && (r_msb != a_msb);
      end else if (is_sub) begin
         stage_in.v = (a_msb != b_msb) && (r_msb != a_msb);
      end
   end

   // Flags as they stand after this cycle's retire; save samples this value so
   // a retire in the save cycle lands in the shadow too.
   assign last = pipe[LAT-1];

   always_comb begin
      retire_flags = flags;
      if (last.valid) begin
         retire_flags = {last.n, last.z, last.c, (last.keep_v ? flags[0] : last.v)};
      end
   end

   always_comb begin
      flags_busy = 1'b0;
      for (int i = 0; i < LAT; i++) begin
         flags_busy = flags_busy | pipe[i].valid;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, which is what makes the pipe shift one
   // stage per clock regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the pipe data fields are reset along with the valid bits;
         // only valid is functionally required, but clearing the whole stage
         // keeps the register file free of X in simulation at negligible cost.
         for (int i = 0; i < LAT; i++) begin
            pipe[i] <= '0;
         end
         flags        <= 4'b0000;
         shadow       <= 4'b0000;
         shadow_valid <= 1'b0;
      end else begin
         pipe[0] <= stage_in;
         for (int i = 1; i < LAT; i++) begin
            pipe[i] <= pipe[i-1];
            if (kill) begin
               pipe[i].valid <= 1'b0;
            end
         end

         if (do_restore) begin
            // Restore beats both the retire and any simultaneous save.
            flags        <= shadow;
            shadow_valid <= 1'b0;
         end else begin
            flags <= retire_flags;
            if (save) begin
               shadow       <= retire_flags;
               shadow_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Producer side of the condition-code path: computes N/Z/C/V from ALU operands and result, pipelines them, and owns the architectural flags register that the condition-check logic reads.
- Provides a busy indication so issue logic can stall conditional instructions until in-flight flag writes retire.
- Provides a one-entry shadow copy for interrupt entry (save) and return (restore), plus a pipeline flush.

Parameters:
- WIDTH, 16, datapath width of op_a, op_b and result.
- LAT, 2, pipeline stages from accept to architectural write; legal range 1..4.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- valid_in  in  1  ALU result valid this cycle.
- opcode  in  4  instruction opcode.
- sbit  in  1  instruction requests a flag update.
- op_a  in  WIDTH  first ALU operand.
- op_b  in  WIDTH  second ALU operand.
- result  in  WIDTH  ALU result.
- alu_carry  in  1  adder carry-out; for subtracts, 1 means no borrow.
- shift_carry  in  1  barrel-shifter carry-out.
- flush  in  1  kill all in-flight updates.
- save  in  1  copy flags into shadow.
- restore  in  1  load flags from shadow.
- flags  out  4  architectural flags, {N,Z,C,V} = flags[3:0].
- flags_busy  out  1  at least one flag update in flight.
- shadow_valid  out  1  shadow holds saved flags.

Behaviour:
- Reset (rst_n low at a clk edge): flags = 4'b0000, shadow = 0, shadow_valid = 0, all pipe valid bits = 0, flags_busy = 0. Reset overrides every other input in that cycle.
- Update qualifier: upd = valid_in && (sbit || opcode == 4'b1000). Opcode 1000 (CMP) always updates.
- Opcode classes:
  - add: 0100, 0101.
  - sub: 0010, 0011, 1000.
  - all others: logical.
- Flag equations, computed from the inputs in the accept cycle:
  - N = result[WIDTH-1].
  - Z = (result == 0).
  - C = alu_carry for add and sub classes; shift_carry for logical.
  - V (add) = (a_msb == b_msb) && (r_msb != a_msb).
  - V (sub) = (a_msb != b_msb) && (r_msb != a_msb).
  - V (logical) = previous architectural V, taken at write time, not at accept time.
- Pipe: LAT stages, each holding {valid, N, Z, C, V, keepV}. Stage 0 loads on every clock with valid = upd. Data shifts one stage per clock. No back-pressure.
- Retire: when the last stage is valid, flags is written at the end of that cycle.
- Latency: flags reflects an update exactly LAT cycles after the accept edge. Example, LAT=2: accepted at edge k, visible after edge k+2.
- flags_busy: combinational OR of all stage valid bits. It is 0 in the accept cycle itself and 1 for the next LAT cycles.
- flush: clears all stage valid bits at the next edge. An update accepted in the same cycle is also discarded. A retire occurring in the flush cycle still commits, because the last stage was valid before the edge.
- save: shadow <= flags value after this cycle's retire (retire data forwarded); shadow_valid <= 1.
- restore:
  - Only takes effect when shadow_valid = 1: flags <= shadow, shadow_valid <= 0, and an implicit flush is applied.
  - When shadow_valid = 0, restore is ignored.
- Priority at one edge: reset > restore > retire. save samples after retire. save together with restore: restore wins and save is ignored.
- The pipe never stalls, so there is no overflow case. Back-to-back updates retire in order, one per cycle.

Test Plan:
- Reset, then ADD (0100, sbit=1) with WIDTH=16, LAT=2, op_a=16'h7FFF, op_b=16'h0001, result=16'h8000, alu_carry=0 -> flags_busy=1 for 2 cycles, then flags=4'b1001.
- CMP (1000, sbit=0) with op_a=op_b=16'h0005, result=0, alu_carry=1 -> flags=4'b0110 two cycles later. Same operands on opcode 0100 with sbit=0 -> flags unchanged, flags_busy stays 0.
- Logical op with prior V=1, result=16'h0000, shift_carry=1 -> flags=4'b0111.
- Three back-to-back updates with results 16'h8000, 16'h0000, 16'h0001 (carries 0) -> flags takes values N, Z, then 0000 on three consecutive cycles.
- Accept update, flush next cycle -> update never retires and flags_busy drops to 0 after the flush edge.
- flags=1001, save, then ADD producing 0110, then restore -> flags=1001 and shadow_valid=0. A second restore -> no change.
